// File: rtl/feedback_step_gen_v2.sv
// Closed-loop feedback step generator, second generation.
// Integrates the demodulated error into a saturating accumulator on each step
// sync, scales it by a power-of-two gain on the delayed sync, and emits a
// clamped step with a one-cycle valid strobe. Also supports constant-step,
// hold and off modes, an accumulator clear, and missed-trigger detection.
module feedback_step_gen_v2 #(
    parameter int ERR_W  = 32,
    parameter int STEP_W = 32,
    parameter int ACC_W  = 40,
    parameter int GAIN_W = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_trig,
    input  logic                     i_trig_dly,
    input  logic signed [ERR_W-1:0]  i_err,
    input  logic [GAIN_W-1:0]        i_gain_sel,
    input  logic [1:0]               i_mode,
    input  logic signed [STEP_W-1:0] i_const_step,
    input  logic [STEP_W-2:0]        i_step_lim,
    input  logic                     i_acc_clr,
    output logic signed [STEP_W-1:0] o_step,
    output logic                     o_step_vld,
    output logic                     o_sat,
    output logic                     o_miss,
    output logic signed [ACC_W-1:0]  o_acc,
    output logic [1:0]               o_mode_q
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_INT   = 2'd1,
        MODE_CONST = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic signed [STEP_W-1:0] val;
        logic                     hit;
    } clamp_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [GAIN_W-1:0]       GAIN_CAP = GAIN_W'(ACC_W - 1);
    localparam logic [GAIN_W-1:0]       GAIN_RST = GAIN_W'(5);

    // Limit a wide signed value to [-lim, +lim]; a zero limit always counts as a hit.
    function automatic clamp_t clamp_f(input logic signed [ACC_W-1:0] v,
                                       input logic signed [ACC_W-1:0] lim);
        logic signed [ACC_W-1:0] neg_lim;
        clamp_t                  r;
        neg_lim = -lim;
        r.val   = v[STEP_W-1:0];
        r.hit   = (lim == '0);
        if (v > lim) begin
            r.val = lim[STEP_W-1:0];
            r.hit = 1'b1;
        end else if (v < neg_lim) begin
            r.val = neg_lim[STEP_W-1:0];
            r.hit = 1'b1;
        end
        return r;
    endfunction

    state_e                   state_q, state_d;
    mode_e                    mode_q, mode_d;
    logic [GAIN_W-1:0]        gain_q, gain_d, gain_eff;
    logic signed [ERR_W-1:0]  err_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum, lim_ext, const_ext;
    logic signed [ACC_W:0]    acc_sum_w;
    logic                     acc_ovf;
    logic signed [STEP_W-1:0] step_q, step_d;
    logic                     vld_q, vld_d, sat_q, sat_d, miss_q, miss_d;
    clamp_t                   shift_c, const_c;

    // Shared datapath: saturating accumulate, gain cap and both clamp sources.
    always_comb begin
        acc_sum_w = (ACC_W+1)'(acc_q) + (ACC_W+1)'(err_q);
        acc_ovf   = acc_sum_w[ACC_W] ^ acc_sum_w[ACC_W-1];
        acc_sum   = acc_ovf ? (acc_sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : acc_sum_w[ACC_W-1:0];
        gain_eff  = (int'(i_gain_sel) > ACC_W - 1) ? GAIN_CAP : i_gain_sel;
        lim_ext   = ACC_W'(i_step_lim);
        const_ext = ACC_W'(i_const_step);
        shift_c   = clamp_f(acc_q >>> gain_q, lim_ext);
        const_c   = clamp_f(const_ext, lim_ext);
    end

    // Next-state and output decode; clear overrides any trigger activity.
    always_comb begin
        // NOTE: every variable gets a default before the branches so no latch is inferred.
        state_d = state_q;
        mode_d  = mode_q;
        gain_d  = gain_q;
        acc_d   = acc_q;
        step_d  = step_q;
        vld_d   = 1'b0;
        miss_d  = 1'b0;
        sat_d   = sat_q;
        if (i_acc_clr) begin
            acc_d   = '0;
            step_d  = '0;
            sat_d   = 1'b0;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_trig) begin
                        mode_d = mode_e'(i_mode);
                        gain_d = gain_eff;
                        case (mode_e'(i_mode))
                            MODE_OFF: begin
                                acc_d  = '0;
                                step_d = '0;
                                vld_d  = 1'b1;
                            end
                            MODE_INT: begin
                                acc_d   = acc_sum;
                                sat_d   = sat_q | acc_ovf;
                                state_d = S_WAIT;
                            end
                            MODE_CONST: begin
                                step_d = const_c.val;
                                sat_d  = sat_q | const_c.hit;
                                vld_d  = 1'b1;
                            end
                            default: ; // hold: only the mode and gain are re-latched
                        endcase
                    end else if (mode_q == MODE_OFF) begin
                        acc_d  = '0;
                        step_d = '0;
                    end
                end
                S_WAIT: begin
                    if (i_trig) begin
                        acc_d  = acc_sum;
                        sat_d  = sat_q | acc_ovf;
                        miss_d = 1'b1;
                    end else if (i_trig_dly) begin
                        step_d  = shift_c.val;
                        sat_d   = sat_q | shift_c.hit;
                        vld_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; error input is registered unconditionally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_OFF;
            gain_q  <= GAIN_RST;
            err_q   <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            vld_q   <= 1'b0;
            sat_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            mode_q  <= mode_d;
            gain_q  <= gain_d;
            err_q   <= i_err;
            acc_q   <= acc_d;
            step_q  <= step_d;
            vld_q   <= vld_d;
            sat_q   <= sat_d;
            miss_q  <= miss_d;
        end
    end

    assign o_step     = step_q;
    assign o_step_vld = vld_q;
    assign o_sat      = sat_q;
    assign o_miss     = miss_q;
    assign o_acc      = acc_q;
    assign o_mode_q   = mode_q;

endmodule

// File: tb/tb_feedback_step_gen_v2.sv
// Directed bench for feedback_step_gen_v2: a table of integrate-mode vectors
// followed by hand-written sequences for the multi-cycle corner cases.
module tb_feedback_step_gen_v2;

    localparam int ERR_W  = 32;
    localparam int STEP_W = 32;
    localparam int ACC_W  = 40;
    localparam int GAIN_W = 6;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     trig, trig_dly, acc_clr;
    logic signed [ERR_W-1:0]  err;
    logic [GAIN_W-1:0]        gain_sel;
    logic [1:0]               mode;
    logic signed [STEP_W-1:0] const_step;
    logic [STEP_W-2:0]        step_lim;
    logic signed [STEP_W-1:0] step;
    logic                     step_vld, sat, miss;
    logic signed [ACC_W-1:0]  acc;
    logic [1:0]               mode_q;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       trig;
        logic       dly;
        longint     acc;
        int         step;
        logic       vld;
        logic [1:0] mq;
    } vec_t;

    vec_t tbl [13];

    feedback_step_gen_v2 #(
        .ERR_W(ERR_W), .STEP_W(STEP_W), .ACC_W(ACC_W), .GAIN_W(GAIN_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_trig_dly(trig_dly),
        .i_err(err), .i_gain_sel(gain_sel), .i_mode(mode), .i_const_step(const_step),
        .i_step_lim(step_lim), .i_acc_clr(acc_clr), .o_step(step), .o_step_vld(step_vld),
        .o_sat(sat), .o_miss(miss), .o_acc(acc), .o_mode_q(mode_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input longint e_acc, input int e_step,
                             input logic e_vld, input logic e_miss, input logic e_sat);
        check({tag, " acc"}, acc, e_acc);
        check({tag, " step"}, step, e_step);
        check({tag, " vld"}, step_vld, e_vld);
        check({tag, " miss"}, miss, e_miss);
        check({tag, " sat"}, sat, e_sat);
    endtask

    // Apply trigger inputs for one clock; outputs are read 1 ns after the edge.
    task automatic tick(input logic t, input logic d);
        trig     = t;
        trig_dly = d;
        @(posedge clk);
        #1;
        trig     = 1'b0;
        trig_dly = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 0,   0,   1'b0, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 100, 0,   1'b0, 2'd1};
        tbl[2]  = '{1'b0, 1'b1, 100, 25,  1'b1, 2'd1};
        tbl[3]  = '{1'b0, 1'b0, 100, 25,  1'b0, 2'd1};
        tbl[4]  = '{1'b1, 1'b0, 200, 25,  1'b0, 2'd1};
        tbl[5]  = '{1'b0, 1'b1, 200, 50,  1'b1, 2'd1};
        tbl[6]  = '{1'b0, 1'b0, 200, 50,  1'b0, 2'd1};
        tbl[7]  = '{1'b1, 1'b0, 300, 50,  1'b0, 2'd1};
        tbl[8]  = '{1'b0, 1'b1, 300, 75,  1'b1, 2'd1};
        tbl[9]  = '{1'b0, 1'b0, 300, 75,  1'b0, 2'd1};
        tbl[10] = '{1'b1, 1'b0, 400, 75,  1'b0, 2'd1};
        tbl[11] = '{1'b0, 1'b1, 400, 100, 1'b1, 2'd1};
        tbl[12] = '{1'b0, 1'b0, 400, 100, 1'b0, 2'd1};

        rst_n      = 1'b0;
        trig       = 1'b0;
        trig_dly   = 1'b0;
        acc_clr    = 1'b0;
        err        = '0;
        gain_sel   = '0;
        mode       = 2'd0;
        const_step = '0;
        step_lim   = 31'd1000000;
        repeat (2) @(posedge clk);
        #2;
        check_out("reset", 0, 0, 1'b0, 1'b0, 1'b0);
        check("reset mode_q", mode_q, 0);
        check("reset gain_q", dut.gain_q, 5);
        @(negedge clk);
        rst_n = 1'b1;

        // Integrate: gain 2, error +100 held across four trigger pairs.
        mode     = 2'd1;
        gain_sel = 6'd2;
        err      = 100;
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].trig, tbl[i].dly);
            check_out($sformatf("int[%0d]", i), tbl[i].acc, tbl[i].step, tbl[i].vld, 1'b0, 1'b0);
            check($sformatf("int[%0d] mode_q", i), mode_q, tbl[i].mq);
        end

        // Clear keeps the latched mode; then a single -1 at gain 3 must stay -1.
        acc_clr = 1'b1;
        tick(1'b0, 1'b0);
        acc_clr = 1'b0;
        check_out("clr", 0, 0, 1'b0, 1'b0, 1'b0);
        check("clr mode_q", mode_q, 1);
        err      = -1;
        gain_sel = 6'd3;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("neg acc", acc, -1);
        tick(1'b0, 1'b1);
        check_out("neg out", -1, -1, 1'b1, 1'b0, 1'b0);

        // Missed delayed trigger: two triggers accumulate twice and pulse o_miss once.
        acc_clr = 1'b1;
        tick(1'b0, 1'b0);
        acc_clr  = 1'b0;
        err      = 10;
        gain_sel = 6'd1;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_out("miss t1", 10, 0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_out("miss t2", 20, 0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("miss pulse end", miss, 0);
        tick(1'b0, 1'b1);
        check_out("miss dly", 20, 10, 1'b1, 1'b0, 1'b0);

        // Mode switch while waiting: the pending delayed trigger still integrates.
        tick(1'b1, 1'b0);
        check("sw acc", acc, 30);
        mode       = 2'd2;
        const_step = -7;
        tick(1'b0, 1'b1);
        check_out("sw dly", 30, 15, 1'b1, 1'b0, 1'b0);
        check("sw dly mode_q", mode_q, 1);
        tick(1'b1, 1'b0);
        check_out("sw const", 30, -7, 1'b1, 1'b0, 1'b0);
        check("sw const mode_q", mode_q, 2);

        // Trigger and delayed trigger together in S_WAIT: the trigger wins.
        mode = 2'd1;
        tick(1'b1, 1'b0);
        check("both acc0", acc, 40);
        tick(1'b1, 1'b1);
        check_out("both", 50, -7, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1);
        check_out("both dly", 50, 25, 1'b1, 1'b0, 1'b0);

        // Hold freezes everything; a lone delayed trigger in idle is ignored; off zeroes.
        mode = 2'd3;
        tick(1'b1, 1'b0);
        check_out("hold", 50, 25, 1'b0, 1'b0, 1'b0);
        check("hold mode_q", mode_q, 3);
        tick(1'b0, 1'b1);
        check_out("hold dly", 50, 25, 1'b0, 1'b0, 1'b0);
        mode = 2'd0;
        tick(1'b1, 1'b0);
        check_out("off", 0, 0, 1'b1, 1'b0, 1'b0);
        check("off mode_q", mode_q, 0);

        // Saturation: 300 full-scale positive errors at gain 0 with a 1000 limit.
        mode     = 2'd1;
        gain_sel = 6'd0;
        step_lim = 31'd1000;
        err      = 32'sh7FFFFFFF;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b1);
        end
        check_out("sat", 64'sd549755813887, 1000, 1'b1, 1'b0, 1'b1);

        // Clear while waiting: everything zero, sticky flag dropped, no strobe.
        tick(1'b1, 1'b0);
        acc_clr = 1'b1;
        tick(1'b0, 1'b1);
        acc_clr = 1'b0;
        check_out("clr wait", 0, 0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check_out("clr idle dly", 0, 0, 1'b0, 1'b0, 1'b0);

        // Constant-step clamping, including a zero limit.
        mode       = 2'd2;
        step_lim   = 31'd3;
        const_step = -9;
        tick(1'b1, 1'b0);
        check_out("const clamp", 0, -3, 1'b1, 1'b0, 1'b1);
        acc_clr = 1'b1;
        tick(1'b0, 1'b0);
        acc_clr    = 1'b0;
        step_lim   = '0;
        const_step = 5;
        tick(1'b1, 1'b0);
        check_out("lim zero", 0, 0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset while waiting for the delayed trigger.
        acc_clr = 1'b1;
        tick(1'b0, 1'b0);
        acc_clr  = 1'b0;
        mode     = 2'd1;
        gain_sel = 6'd2;
        step_lim = 31'd1000000;
        err      = 64;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("rst pre acc", acc, 64);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst wait", 0, 0, 1'b0, 1'b0, 1'b0);
        check("rst wait mode_q", mode_q, 0);
        check("rst wait gain_q", dut.gain_q, 5);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b1);
        check_out("rst after dly", 0, 0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/feedback_step_gen_v2.md
Name: feedback_step_gen_v2

Overview:
Parametrised successor of the closed-loop feedback step generator for the gyro modulation chain. It sits between the error demodulator (o_err_DAC, o_step_sync, o_step_sync_dly) and the ramp/step DAC path. It integrates the demodulated error into a wide saturating accumulator and scales it by a power-of-two gain. It outputs a clamped step with a valid strobe. Compared with v1 it adds:
- a hold mode;
- trigger-aligned mode and gain switching;
- accumulator and output saturation;
- an accumulator clear;
- missed-trigger detection.

Parameters:
ERR_W, 32, signed error input width
STEP_W, 32, signed step output width
ACC_W, 40, signed accumulator width (ACC_W >= ERR_W+1, ACC_W >= STEP_W)
GAIN_W, 6, width of shift-amount select

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_trig  in  1  step sync pulse (1 cycle)
i_trig_dly  in  1  delayed step sync pulse (1 cycle, arrives 1..N cycles after i_trig)
i_err  in  ERR_W  signed demodulated error
i_gain_sel  in  GAIN_W  right-shift amount applied to the accumulator
i_mode  in  2  0=off, 1=integrate, 2=constant step, 3=hold
i_const_step  in  STEP_W  signed constant step for mode 2
i_step_lim  in  STEP_W-1  positive magnitude limit for o_step
i_acc_clr  in  1  synchronous clear of accumulator and step
o_step  out  STEP_W  signed feedback step
o_step_vld  out  1  1-cycle pulse, coincident with each o_step update
o_sat  out  1  sticky; set on any accumulator or output saturation, cleared by i_acc_clr
o_miss  out  1  1-cycle pulse; i_trig arrived while still awaiting i_trig_dly
o_acc  out  ACC_W  accumulator value (debug)
o_mode_q  out  2  active (latched) mode

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_rst_n.
- Reset values:
  - o_step=0, o_step_vld=0, o_sat=0, o_miss=0, o_acc=0, o_mode_q=0.
  - err_q=0, gain_q=5, FSM=S_IDLE.
- Input registering: err_q <= i_err every cycle. Accumulation uses err_q, i.e. i_err from the cycle before i_trig.
- Mode and gain latching:
  - When i_trig is high and the FSM is in S_IDLE: mode_q <= i_mode and gain_q <= min(i_gain_sel, ACC_W-1).
  - The new mode governs that same trigger's action.
  - Mode and gain never change between i_trig and i_trig_dly.
- FSM states: S_IDLE and S_WAIT.
  - S_IDLE + i_trig, effective mode 1: acc <= sat(acc + sext(err_q)); go to S_WAIT.
  - S_WAIT + i_trig_dly: o_step <= clamp(acc >>> gain_q); o_step_vld=1 next cycle; go to S_IDLE.
  - S_WAIT + i_trig (no dly): accumulate again, pulse o_miss, stay in S_WAIT.
  - i_trig and i_trig_dly in the same cycle: i_trig wins and i_trig_dly is ignored.
  - i_trig_dly in S_IDLE: ignored.
- Mode 2: on i_trig, o_step <= clamp(i_const_step) and o_step_vld pulses. acc holds. FSM stays in S_IDLE.
- Mode 0:
  - On latch, acc, o_step and the FSM return to 0/S_IDLE.
  - o_step_vld pulses once with o_step=0.
  - While mode_q=0, acc and o_step are forced to 0.
- Mode 3: acc and o_step are frozen. No vld pulse. Triggers only re-latch mode and gain.
- sat():
  - Result computed in ACC_W+1 bits and saturated to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1].
  - Saturation sets o_sat.
- clamp():
  - Value limited to [-i_step_lim, +i_step_lim], then truncated to STEP_W.
  - Clamping sets o_sat.
  - i_step_lim=0 forces o_step=0 with o_sat set.
- Arithmetic shift is sign-preserving: (-1)>>>n = -1.
- i_acc_clr:
  - Highest priority after reset.
  - acc, o_step and o_sat are cleared to 0; FSM goes to S_IDLE; o_step_vld=0 that cycle.
  - mode_q is unchanged.
- Reset mid-operation (S_WAIT): everything returns to reset values immediately. No vld pulse is emitted.
- Latency:
  - Integrate: i_trig_dly at cycle t gives o_step/o_step_vld at t+1.
  - Constant: i_trig at t gives output at t+1.

Test Plan:
- Integrate:
  - Stimulus: mode 1, gain 2, err=+100 held; 4 trig/trig_dly pairs.
  - Required: acc 100, 200, 300, 400; o_step 25, 50, 75, 100; one vld per pair at t+1 of trig_dly.
- Negative rounding:
  - Stimulus: mode 1, gain 3, single err=-1.
  - Required: acc=-1, o_step=-1 (arithmetic shift).
- Saturation:
  - Stimulus: ACC_W=40, preload by 300 triggers of err=0x7FFFFFFF, gain 0, i_step_lim=1000.
  - Required: o_step=1000, o_sat=1; acc pinned at 2^39-1.
- Mode switch mid-cycle:
  - Stimulus: mode 1, i_trig, then set i_mode=2 and i_const_step=-7 before i_trig_dly.
  - Required: the dly output uses integrate; the next i_trig gives o_step=-7 and o_mode_q=2.
- Missed dly:
  - Stimulus: two i_trig without i_trig_dly, err=10.
  - Required: o_miss pulses once, acc=20; then trig_dly gives o_step=20>>>gain.
- Clear and reset:
  - Stimulus: i_acc_clr in S_WAIT.
  - Required: acc=0, o_step=0, o_sat=0, no vld.
  - Stimulus: i_rst_n low while in S_WAIT.
  - Required: all outputs 0, gain_q=5.
